// File: rtl/uart_key_decoder.sv
// rtl/uart_key_decoder.sv - UART keyboard byte decoder with command FIFO and held direction outputs
module uart_key_decoder #(
    parameter int HOLD_CLKS = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxDone,
    input  logic [7:0] rxByte,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       dir_up,
    output logic       dir_left,
    output logic       dir_down,
    output logic       dir_right,
    output logic       paused,
    output logic       restart,
    output logic [7:0] err_count,
    output logic       overflow
);

    localparam int CNT_W = $clog2(HOLD_CLKS);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CLKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dir_state_t;

    logic       key_valid;
    logic [2:0] key_code;
    logic       key_rx;
    logic       key_bad;
    logic       dir_hit;
    logic       pause_hit;
    logic       restart_hit;

    // Setting bit 5 folds upper case onto lower case; only the two letter
    // cases of each key collapse onto the same value.
    always_comb begin
        key_valid = 1'b0;
        key_code  = 3'd0;
        case (rxByte | 8'h20)
            8'h77: begin key_valid = 1'b1; key_code = 3'd0; end
            8'h61: begin key_valid = 1'b1; key_code = 3'd1; end
            8'h73: begin key_valid = 1'b1; key_code = 3'd2; end
            8'h64: begin key_valid = 1'b1; key_code = 3'd3; end
            8'h70: begin key_valid = 1'b1; key_code = 3'd4; end
            8'h72: begin key_valid = 1'b1; key_code = 3'd5; end
            default: begin
                key_valid = 1'b0;
                key_code  = 3'd0;
            end
        endcase
    end

    assign key_rx      = rxDone & key_valid;
    assign key_bad     = rxDone & ~key_valid;
    assign dir_hit     = key_rx & ~key_code[2];
    assign pause_hit   = key_rx & (key_code == 3'd4);
    assign restart_hit = key_rx & (key_code == 3'd5);

    // Command FIFO, first-word-fall-through
    logic [2:0] fifo_mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_full;
    logic       pop;
    logic       push;
    logic       drop;

    assign fifo_full = (fifo_cnt == 3'd4);
    assign pop       = cmd_valid & cmd_ready;
    assign push      = key_rx & (~fifo_full | pop);
    assign drop      = key_rx & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 3'd0;
            end
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= key_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign cmd_valid = (fifo_cnt != 3'd0);
    assign cmd_code  = cmd_valid ? fifo_mem[rd_ptr] : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paused    <= 1'b0;
            restart   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            restart <= restart_hit;
            if (restart_hit) begin
                paused <= 1'b0;
            end else if (pause_hit) begin
                paused <= ~paused;
            end
            if (key_bad && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Direction hold FSM
    dir_state_t       state;
    dir_state_t       state_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    logic [1:0]       dir_sel;
    logic [1:0]       dir_sel_next;
    logic             dir_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            dir_sel  <= 2'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            dir_sel  <= dir_sel_next;
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        dir_sel_next  = dir_sel;
        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
        // A fresh direction byte always wins over the countdown.
        if (dir_hit) begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
            dir_sel_next  = key_code[1:0];
        end
        if (restart_hit) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
        end
    end

    // Pause masks the outputs only; the hold window keeps running underneath.
    assign dir_active = (state == HOLD) & ~paused;
    assign dir_up     = dir_active & (dir_sel == 2'd0);
    assign dir_left   = dir_active & (dir_sel == 2'd1);
    assign dir_down   = dir_active & (dir_sel == 2'd2);
    assign dir_right  = dir_active & (dir_sel == 2'd3);

endmodule

// File: tb/tb_uart_key_decoder.sv
// tb/tb_uart_key_decoder.sv - self-checking bench for uart_key_decoder
module tb_uart_key_decoder;

    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxDone;
    logic [7:0] rxByte;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic       dir_up, dir_left, dir_down, dir_right;
    logic       paused;
    logic       restart;
    logic [7:0] err_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_key_decoder #(.HOLD_CLKS(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxDone    (rxDone),
        .rxByte    (rxByte),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .dir_up    (dir_up),
        .dir_left  (dir_left),
        .dir_down  (dir_down),
        .dir_right (dir_right),
        .paused    (paused),
        .restart   (restart),
        .err_count (err_count),
        .overflow  (overflow)
    );

    logic [3:0]  dirs;
    logic [18:0] all_outs;
    assign dirs     = {dir_right, dir_down, dir_left, dir_up};
    assign all_outs = {cmd_valid, cmd_code, dirs, paused, restart, err_count, overflow};

    typedef struct {
        logic [7:0] b;
        logic       valid;
        logic [2:0] code;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end on a falling edge; one send = one strobe edge.
    task automatic send(input logic [7:0] b);
        rxDone = 1'b1;
        rxByte = b;
        @(negedge clk);
        rxDone = 1'b0;
        rxByte = 8'h77;
    endtask

    task automatic do_reset();
        rxDone    = 1'b0;
        cmd_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic count_high(input int idx, output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (dirs[idx]) n++;
            @(negedge clk);
        end
    endtask

    task automatic pop_all();
        cmd_ready = 1'b1;
        for (int i = 0; i < 8 && cmd_valid; i++) @(negedge clk);
        cmd_ready = 1'b0;
        check("pop_all_empty", cmd_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_err;
        logic [2:0] exp_q [4];

        tbl[0]  = '{8'h77, 1'b1, 3'd0};
        tbl[1]  = '{8'h57, 1'b1, 3'd0};
        tbl[2]  = '{8'h61, 1'b1, 3'd1};
        tbl[3]  = '{8'h41, 1'b1, 3'd1};
        tbl[4]  = '{8'h78, 1'b0, 3'd0};
        tbl[5]  = '{8'h73, 1'b1, 3'd2};
        tbl[6]  = '{8'h53, 1'b1, 3'd2};
        tbl[7]  = '{8'h00, 1'b0, 3'd0};
        tbl[8]  = '{8'h64, 1'b1, 3'd3};
        tbl[9]  = '{8'h44, 1'b1, 3'd3};
        tbl[10] = '{8'hF7, 1'b0, 3'd0};
        tbl[11] = '{8'h70, 1'b1, 3'd4};
        tbl[12] = '{8'h50, 1'b1, 3'd4};
        tbl[13] = '{8'h71, 1'b0, 3'd0};
        tbl[14] = '{8'h72, 1'b1, 3'd5};
        tbl[15] = '{8'h52, 1'b1, 3'd5};
        tbl[16] = '{8'h20, 1'b0, 3'd0};
        tbl[17] = '{8'h37, 1'b0, 3'd0};

        // Reset state, with a strobe held during reset that must be discarded
        rst_n = 1'b0; rxDone = 1'b0; rxByte = 8'h00; cmd_ready = 1'b0;
        #3;
        check("reset_outputs", all_outs, 0);
        rxDone = 1'b1; rxByte = 8'h77;
        @(negedge clk);
        @(negedge clk);
        rxDone = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("strobe_in_reset_outputs", all_outs, 0);

        // Bytes with rxDone low are ignored
        rxByte = 8'h78;
        repeat (3) @(negedge clk);
        check("ignored_byte_outputs", all_outs, 0);

        // 'w' holds dir_up for exactly HOLD cycles, queued as code 0
        send(8'h77);
        check("w_dir_up", dir_up, 1);
        check("w_cmd_valid", cmd_valid, 1);
        check("w_cmd_code", cmd_code, 0);
        count_high(0, n);
        check("w_hold_cycles", n, HOLD);
        pop_all();

        // Same direction reloads, a different one switches at once
        send(8'h77);
        repeat (5) @(negedge clk);
        send(8'h77);
        count_high(0, n);
        check("w_reload_cycles", n, HOLD);
        send(8'h77);
        repeat (2) @(negedge clk);
        send(8'h61);
        check("switch_to_left", dirs, 4'b0010);
        pop_all();

        // Decode table, consumer always ready
        do_reset();
        cmd_ready = 1'b1;
        exp_err   = 0;
        for (int i = 0; i < 18; i++) begin
            send(tbl[i].b);
            check($sformatf("tbl%0d_valid", i), cmd_valid, tbl[i].valid);
            if (tbl[i].valid) check($sformatf("tbl%0d_code", i), cmd_code, tbl[i].code);
            else exp_err++;
        end
        check("tbl_err_count", err_count, exp_err);
        cmd_ready = 1'b0;

        // 'D','x','?' -> FIFO {3}, err 2, right held
        do_reset();
        send(8'h44); send(8'h78); send(8'h3F);
        check("dx_code", cmd_code, 3);
        check("dx_err", err_count, 2);
        check("dx_right", dir_right, 1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("dx_single_entry", cmd_valid, 0);

        // Fill, overflow, push during pop on a full FIFO
        do_reset();
        send(8'h77); send(8'h61); send(8'h73); send(8'h64);
        check("fill4_no_overflow", overflow, 0);
        send(8'h70);
        check("fill5_overflow", overflow, 1);
        check("fill5_head", cmd_code, 0);
        rxDone = 1'b1; rxByte = 8'h72; cmd_ready = 1'b1;
        @(negedge clk);
        rxDone = 1'b0; cmd_ready = 1'b0;
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd5};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), cmd_valid, 1);
            check($sformatf("drain%0d_code", i), cmd_code, exp_q[i]);
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
        end
        check("drain_empty", cmd_valid, 0);
        check("overflow_sticky", overflow, 1);
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h64);
        cmd_ready = 1'b0;
        check("empty_pop_then_push_valid", cmd_valid, 1);
        check("empty_pop_then_push_code", cmd_code, 3);

        // Push and pop together on a 1-entry FIFO
        do_reset();
        send(8'h61);
        rxDone = 1'b1; rxByte = 8'h64; cmd_ready = 1'b1;
        @(negedge clk);
        rxDone = 1'b0; cmd_ready = 1'b0;
        check("one_entry_swap_valid", cmd_valid, 1);
        check("one_entry_swap_code", cmd_code, 3);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("one_entry_swap_empty", cmd_valid, 0);

        // Pause masks direction while the hold window keeps running
        do_reset();
        send(8'h70);
        check("pause_on", paused, 1);
        send(8'h73);
        check("paused_down_low", dir_down, 0);
        send(8'h50);
        check("pause_off", paused, 0);
        check("unpaused_down_high", dir_down, 1);
        count_high(2, n);
        check("unpaused_remaining", n, HOLD - 1);
        check("pause_fifo_head", cmd_code, 4);

        // Restart pulse, clears pause and hold, keeps FIFO
        do_reset();
        send(8'h77);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        send(8'h70);
        check("rs_paused", paused, 1);
        send(8'h72);
        check("rs_pulse", restart, 1);
        check("rs_unpaused", paused, 0);
        check("rs_dirs_low", dirs, 0);
        @(negedge clk);
        check("rs_pulse_end", restart, 0);
        check("rs_dirs_idle", dirs, 0);
        check("rs_fifo0", cmd_code, 4);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("rs_fifo1", cmd_code, 5);
        @(negedge clk);
        cmd_ready = 1'b0;
        check("rs_fifo_empty", cmd_valid, 0);

        // err_count saturates at 255
        do_reset();
        for (int i = 0; i < 260; i++) send(8'h3F);
        check("err_saturate", err_count, 255);
        check("err_no_fifo", cmd_valid, 0);

        // Asynchronous reset mid-hold with 3 queued entries
        do_reset();
        send(8'h61); send(8'h73); send(8'h64);
        check("pre_reset_right", dir_right, 1);
        #2;
        rst_n  = 1'b0;
        #1;
        check("async_reset_outputs", all_outs, 0);
        rxDone = 1'b1; rxByte = 8'h77;
        @(negedge clk);
        @(negedge clk);
        rxDone = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_outputs", all_outs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
